// File: rtl/md_unit.sv
// md_unit -- iterative RV32M multiply/divide unit.
//
// Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 cycles, next to the
// single-cycle ALU. Requests and responses both use a valid/ready handshake.
// Only one operation is in flight at a time; the core stalls meanwhile.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    synchronous active-low reset
//   valid_i   request valid            ready_o   accepting (IDLE only)
//   md_op_i   funct3 (0 MUL .. 7 REMU)
//   op_a_i    rs1 (dividend / multiplicand)
//   op_b_i    rs2 (divisor / multiplier)
//   valid_o   result valid, held until ready_i
//   ready_i   consumer accepts result
//   result_o  registered result
//
// Build option: MD_UNIT_FAST_MUL_EN -- multiplies use a single 33x33 signed
// multiplier at acceptance (latency 1); divides stay iterative.
module md_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef struct packed {
    logic [2:0] op;
    logic       neg;   // final result must be negated
  } md_ctl_t;

  state_t            state_q, state_d;
  md_ctl_t           ctl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt;
  logic [XLEN-1:0]   opnd_q, result_q;

  logic            accept, is_mul, is_rem, sgn_a, sgn_b, a_neg, b_neg;
  logic            div_zero, div_ovf, special, last_iter;
  logic [XLEN-1:0] a_abs, b_abs, special_res, final_res;

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

  // ---- acceptance decode ----
  assign accept = valid_i & ready_o;
  assign is_mul = ~md_op_i[2];
  assign is_rem = md_op_i[2] & md_op_i[1];
  assign sgn_a  = (md_op_i == OP_MULH) | (md_op_i == OP_MULHSU) |
                  (md_op_i == OP_DIV)  | (md_op_i == OP_REM);
  assign sgn_b  = (md_op_i == OP_MULH) | (md_op_i == OP_DIV) | (md_op_i == OP_REM);
  assign a_neg  = sgn_a & op_a_i[XLEN-1];
  assign b_neg  = sgn_b & op_b_i[XLEN-1];
  assign a_abs  = a_neg ? -op_a_i : op_a_i;
  assign b_abs  = b_neg ? -op_b_i : op_b_i;

  assign div_zero = md_op_i[2] & (op_b_i == '0);
  // sgn_a & md_op_i[2] selects exactly DIV/REM
  assign div_ovf  = sgn_a & md_op_i[2] & (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b_i);

`ifdef MD_UNIT_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN-1:0] fprod;
  assign fa    = {sgn_a & op_a_i[XLEN-1], op_a_i};
  assign fb    = {sgn_b & op_b_i[XLEN-1], op_b_i};
  // only the low 64 bits of the 66-bit product are ever selected
  assign fprod = (2*XLEN)'(fa) * (2*XLEN)'(fb);
`endif

  // Results that bypass the iterative datapath and land in DONE at acceptance.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (div_zero) begin
      special     = 1'b1;
      special_res = md_op_i[1] ? op_a_i : '1;
    end else if (div_ovf) begin
      special     = 1'b1;
      special_res = md_op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`ifdef MD_UNIT_FAST_MUL_EN
    else if (is_mul) begin
      special     = 1'b1;
      special_res = (md_op_i == OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
`endif
  end

  // ---- FSM ----
  assign last_iter = (cnt_q == CNT_W'(XLEN-1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---- one iteration ----
  // acc_q = {hi, lo}. Multiply: hi is the running partial product, lo holds
  // the not-yet-consumed multiplier bits; shifts right each cycle.
  // Divide: hi is the partial remainder, lo shifts the dividend out at the top
  // and quotient bits in at the bottom.
  logic [XLEN:0]   sum, shl;
  logic [XLEN-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    shl     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    // when shl >= divisor the difference is below the divisor, so 32 bits hold it
    diff    = shl[XLEN-1:0] - opnd_q;
    acc_nxt = acc_q;
    if (!ctl_q.op[2])
      acc_nxt = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    else if (shl >= {1'b0, opnd_q})
      acc_nxt = {diff, acc_q[XLEN-2:0], 1'b1};
    else
      acc_nxt = {shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // ---- sign correction and result select ----
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  always_comb begin
    prod_s = ctl_q.neg ? -acc_nxt : acc_nxt;
    quo_s  = ctl_q.neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_s  = ctl_q.neg ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    case (ctl_q.op)
      OP_MUL:                       final_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo_s;
      default:                      final_res = rem_s;
    endcase
  end

  // ---- datapath registers ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctl_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          ctl_q.op  <= md_op_i;
          // remainder follows the dividend; everything else is sign(a)^sign(b)
          ctl_q.neg <= is_rem ? a_neg : (a_neg ^ b_neg);
          cnt_q     <= '0;
          acc_q     <= {{XLEN{1'b0}}, (is_mul ? b_abs : a_abs)};
          opnd_q    <= is_mul ? a_abs : b_abs;
          if (special) result_q <= special_res;
        end
        CALC: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) result_q <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- directed and randomized checks for md_unit.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_ni, valid_i, ready_i, ready_o, valid_o;
  logic [2:0]  md_op_i;
  logic [31:0] op_a_i, op_b_i, result_o;

  int total = 0;
  int bad   = 0;
  bit acc_flag;

`ifdef MD_UNIT_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;
  localparam int TMO     = 100;

  always #5 clk = ~clk;

  md_unit dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .md_op_i (md_op_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .result_o(result_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // A result may only be presented for a request that was actually accepted.
  always @(posedge clk) begin
    if (!rst_ni)                acc_flag <= 1'b0;
    else if (valid_i && ready_o) acc_flag <= 1'b1;
    else if (valid_o && ready_i) acc_flag <= 1'b0;
  end

  always @(negedge clk)
    if (rst_ni && valid_o) check("valid_without_accept", {31'b0, acc_flag}, 32'd1);

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] xa, xb, sp;
    logic [63:0]        up;
    sa = a; sb = b; xa = sa; xb = sb;
    up = {32'b0, a} * {32'b0, b};
    case (op)
      3'd0: return up[31:0];
      3'd1: begin sp = xa * xb; return sp[63:32]; end
      3'd2: begin sp = xa * $signed({32'b0, b}); return sp[63:32]; end
      3'd3: return up[63:32];
      3'd4: if (b == 0) return 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            else return sa / sb;
      3'd5: if (b == 0) return 32'hFFFFFFFF; else return a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            else return sa % sb;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 0) return 0;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
    return DIV_LAT;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request; edges = rising edges after the accept edge until valid_o
  // is seen (0 means valid in the cycle right after acceptance). Inputs are
  // scrambled after acceptance to show they are not resampled. One more edge
  // follows so that with ready_i=1 the unit is back in IDLE on return.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int edges, output bit rdy_low);
    @(negedge clk);
    valid_i = 1'b1; md_op_i = op; op_a_i = a; op_b_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0; md_op_i = ~op; op_a_i = ~a; op_b_i = ~b;
    edges = 0; rdy_low = 1'b1;
    while (!valid_o && edges < TMO) begin
      if (ready_o) rdy_low = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    res = result_o;
    @(posedge clk); #1;
  endtask

  task automatic dir(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input int exp_lat, input bit chk_rdy);
    logic [31:0] res; int edges; bit rdy_low;
    do_op(op, a, b, res, edges, rdy_low);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_lat"}, 32'(edges), 32'(exp_lat));
    if (chk_rdy) check({tag, "_ready_low"}, {31'b0, rdy_low}, 32'd1);
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [2:0]  op;
    int          edges;
    bit          rdy_low;

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    md_op_i = 3'd0; op_a_i = 32'h0; op_b_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'h0);
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    rst_ni = 1'b1;

    // multiplies
    dir("mul",    3'd0, 32'd7,        32'd6,        32'h0000002A, MUL_LAT, 1'b0);
    dir("mul_neg",3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, MUL_LAT, 1'b0);
    dir("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT, 1'b0);
    dir("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 1'b0);
    dir("mulhsu", 3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT, 1'b0);
    // divides
    dir("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, 1'b1);
    dir("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, 1'b1);
    dir("divu",   3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, DIV_LAT, 1'b1);
    dir("remu",   3'd7, 32'hFFFFFFF9, 32'd2,        32'h00000001, DIV_LAT, 1'b1);
    dir("div_nb", 3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT, 1'b1);
    dir("rem_nb", 3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT, 1'b1);
    // special cases
    dir("div0",   3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 1'b0);
    dir("rem0",   3'd6, 32'd5,        32'd0,        32'h00000005, 0, 1'b0);
    dir("divu0",  3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 1'b0);
    dir("div_ovf",3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1'b0);
    dir("rem_ovf",3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 1'b0);

    // backpressure: result held, requests ignored while in DONE
    ready_i = 1'b0;
    do_op(3'd5, 32'd100, 32'd7, res, edges, rdy_low);
    check("bp_res", res, 32'h0000000E);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_i = (i % 2 == 0); md_op_i = 3'd0; op_a_i = 32'd3; op_b_i = 32'd3;
      @(posedge clk); #1;
      check("bp_valid_held", {31'b0, valid_o}, 32'd1);
      check("bp_result_held", result_o, 32'h0000000E);
    end
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'b0, valid_o}, 32'd0);
    check("bp_release_ready", {31'b0, ready_o}, 32'd1);
    @(posedge clk); #1;
    check("bp_not_queued", {31'b0, ready_o}, 32'd1);

    // reset in the middle of a divide
    @(negedge clk);
    valid_i = 1'b1; md_op_i = 3'd4; op_a_i = 32'd1000; op_b_i = 32'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", {31'b0, valid_o}, 32'd0);
    check("mid_rst_result", result_o, 32'h0);
    check("mid_rst_ready", {31'b0, ready_o}, 32'd1);
    rst_ni = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_discarded", {31'b0, valid_o}, 32'd0);
    dir("divu_after_rst", 3'd5, 32'd100, 32'd7, 32'h0000000E, DIV_LAT, 1'b1);

    // randomized against the behavioural model
    for (int n = 0; n < 1000; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      do_op(op, a, b, res, edges, rdy_low);
      check("rand_res", res, model(op, a, b));
      check("rand_lat", 32'(edges), 32'(lat_of(op, a, b)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
